lz77_decoder: RTL and testbench
===============================

LZ77_DECODER -- requirements
Module: lz77_decoder

Interface
REQ-001 Parameter DATAWIDTH, default 8; width of one symbol byte.
REQ-002 Parameter CURSOR_WIDTH, default 7; width of offset, length and window pointer; window depth is 2^CURSOR_WIDTH = 128.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 tok_valid  input  1  a token is present on tok_* this cycle.
REQ-006 tok_ready  output  1  the decoder accepts a token this cycle.
REQ-007 tok_offset  input  CURSOR_WIDTH  back-distance into history; 1 means the previous byte.
REQ-008 tok_length  input  CURSOR_WIDTH  number of bytes to copy; 0 means literal only.
REQ-009 tok_literal  input  DATAWIDTH  byte emitted after the copy.
REQ-010 out_valid  output  1  out_data holds a decoded byte.
REQ-011 out_ready  input  1  the sink consumes the byte this cycle.
REQ-012 out_data  output  DATAWIDTH  decoded byte, registered.
REQ-013 out_last  output  1  out_data is the last byte (the literal) of its token.
REQ-014 tok_err  output  1  one-cycle pulse when a token with offset 0 and nonzero length is accepted.

Function
REQ-015 FSM states: IDLE, COPY, LIT.
REQ-016 tok_ready = (state == IDLE); a token is accepted on the edge where tok_valid && tok_ready; offset, length and literal are latched at that edge.
REQ-017 On accept: next state is COPY if length != 0 and offset != 0; otherwise LIT.
REQ-018 On accept with offset == 0 and length != 0: tok_err = 1 for the next cycle, the copy is skipped, and only the literal is emitted.
REQ-019 Output register load condition: load = (!out_valid || out_ready) && state in {COPY, LIT}.
REQ-020 Load in COPY: out_data <= win[wr_ptr - offset] (mod 128); win[wr_ptr] <= the same byte; wr_ptr += 1; remaining -= 1; out_last <= 0.
REQ-021 When remaining reaches 0 during a COPY load, the next state is LIT.
REQ-022 Load in LIT: out_data <= literal; win[wr_ptr] <= literal; wr_ptr += 1; out_last <= 1; next state IDLE.
REQ-023 out_valid <= 1 on a load; out_valid <= 0 on out_ready with no load; otherwise out_valid holds.
REQ-024 Overlapping copies (offset <= length) are legal: each byte is written to win before the next read, so offset 1 repeats the previous byte.
REQ-025 wr_ptr wraps 127 -> 0; the read index is the modulo-128 difference.
REQ-026 Reading history never written since reset returns 0.
REQ-027 Latency: the first byte is out_valid one cycle after token accept; with out_ready held 1, throughput is 1 byte/cycle; a token of length L produces L+1 bytes.
REQ-028 While out_valid && !out_ready: out_data, out_last, wr_ptr, remaining and the FSM state all hold.
REQ-029 The next token is accepted in the cycle after the LIT load, which leaves a 1-cycle bubble between tokens.

Reset
REQ-030 While rst is high: state = IDLE, wr_ptr = 0, remaining = 0, all 128 window entries = 0, out_valid = 0, out_data = 0, out_last = 0, tok_err = 0.
REQ-031 rst asserted mid-COPY aborts the token immediately; no partial byte is presented after reset.
REQ-032 tok_ready is 0 while rst is high and becomes 1 in the first cycle after release.

Verification
REQ-033 Literal: after reset, token (offset 0, length 0, literal 0x49) -> one byte 0x49 with out_last = 1, one cycle after accept.
REQ-034 Overlap: literal 0x41, then token (offset 1, length 4, literal 0x42), out_ready = 1 -> 0x41, 0x41, 0x41, 0x41, 0x41, 0x42; out_last is 1 only on the two literal bytes.
REQ-035 Backpressure: same stream with out_ready toggled 1,0,0,1 repeating -> identical byte sequence with no loss or duplication, and out_data stable while stalled.
REQ-036 Wrap: 130 literal tokens carrying bytes 0..129, then token (offset 3, length 2, literal 0xFF) -> outputs 127, 128, 0xFF, with the reads crossing the pointer wrap.
REQ-037 Error and reset: token (offset 0, length 5, literal 0x10) -> tok_err pulses once and the output is only 0x10; rst asserted in the 2nd cycle of a length-6 copy -> out_valid is 0 immediately and tok_ready is 1 after release.

Source files
------------

// File: rtl/lz77_decoder_if.sv
// Token and byte stream bundle for the LZ77 decoder.
// The decoder uses the slave modport; the token source and byte sink use master.
interface lz77_decoder_if #(
   parameter int DATAWIDTH    = 8,
   parameter int CURSOR_WIDTH = 7
);
   logic                    tok_valid;
   logic                    tok_ready;
   logic [CURSOR_WIDTH-1:0] tok_offset;
   logic [CURSOR_WIDTH-1:0] tok_length;
   logic [DATAWIDTH-1:0]    tok_literal;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATAWIDTH-1:0]    out_data;
   logic                    out_last;
   logic                    tok_err;

   modport master (
      output tok_valid, tok_offset, tok_length, tok_literal, out_ready,
      input  tok_ready, out_valid, out_data, out_last, tok_err
   );

   modport slave (
      input  tok_valid, tok_offset, tok_length, tok_literal, out_ready,
      output tok_ready, out_valid, out_data, out_last, tok_err
   );
endinterface

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands (offset, length, literal) tokens into a byte
// stream using a 2^CURSOR_WIDTH entry history window.
module lz77_decoder #(
   parameter int DATAWIDTH    = 8,
   parameter int CURSOR_WIDTH = 7
) (
   input logic          clk,
   input logic          rst,
   lz77_decoder_if.slave bus
);
   localparam int DEPTH = 1 << CURSOR_WIDTH;

   typedef enum logic [1:0] {IDLE, COPY, LIT} state_t;

   state_t                  state;
   state_t                  next_state;
   logic [CURSOR_WIDTH-1:0] wr_ptr;
   logic [CURSOR_WIDTH-1:0] remaining;
   logic [CURSOR_WIDTH-1:0] offset_q;
   logic [DATAWIDTH-1:0]    literal_q;
   logic [DATAWIDTH-1:0]    win [DEPTH];

   logic                    accept;
   logic                    go_copy;
   logic                    load;
   logic [CURSOR_WIDTH-1:0] rd_idx;
   logic [DATAWIDTH-1:0]    load_byte;

   assign bus.tok_ready = (state == IDLE) && !rst;
   assign accept        = bus.tok_valid && bus.tok_ready;
   assign go_copy       = (bus.tok_length != '0) && (bus.tok_offset != '0);
   assign load          = (!bus.out_valid || bus.out_ready) && (state == COPY || state == LIT);
   // Index arithmetic wraps naturally at the window depth.
   assign rd_idx        = wr_ptr - offset_q;
   assign load_byte     = (state == COPY) ? win[rd_idx] : literal_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = go_copy ? COPY : LIT;
            end
         end
         COPY: begin
            if (load && remaining == CURSOR_WIDTH'(1)) begin
               next_state = LIT;
            end
         end
         LIT: begin
            if (load) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Every emitted byte is also written back so later copies can reference it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr        <= '0;
         remaining     <= '0;
         offset_q      <= '0;
         literal_q     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.tok_err   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            win[i] <= '0;
         end
      end else begin
         bus.tok_err <= accept && (bus.tok_offset == '0) && (bus.tok_length != '0);
         if (accept) begin
            offset_q  <= bus.tok_offset;
            literal_q <= bus.tok_literal;
            remaining <= go_copy ? bus.tok_length : '0;
         end
         if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= load_byte;
            bus.out_last  <= (state == LIT);
            win[wr_ptr]   <= load_byte;
            wr_ptr        <= wr_ptr + 1'b1;
            if (state == COPY) begin
               remaining <= remaining - 1'b1;
            end
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_lz77_decoder.sv
// Directed self-checking bench for lz77_decoder: literal, overlap copy,
// backpressure, pointer wrap, offset-0 error and mid-copy reset.
module tb_lz77_decoder;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   err_pulses = 0;
   logic bp_mode = 1'b0;
   int   bp_idx = 0;
   logic [7:0] got_data [$];
   logic       got_last [$];

   lz77_decoder_if #(.DATAWIDTH(8), .CURSOR_WIDTH(7)) bus ();

   lz77_decoder #(.DATAWIDTH(8), .CURSOR_WIDTH(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Sink ready changes just after each rising edge, in pattern 1,0,0,1 when stalling.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            bus.out_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
            bp_idx++;
         end else begin
            bus.out_ready = 1'b1;
         end
      end
   end

   logic       stalled = 1'b0;
   logic [7:0] stall_data;
   logic       stall_last;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               checks++;
               if (bus.out_valid !== 1'b1 || bus.out_data !== stall_data || bus.out_last !== stall_last) begin
                  errors++;
                  $display("[TB] FAIL stall_hold: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                           bus.out_valid, bus.out_data, bus.out_last, stall_data, stall_last);
               end
            end
            if (bus.out_valid && bus.out_ready) begin
               got_data.push_back(bus.out_data);
               got_last.push_back(bus.out_last);
            end
            if (bus.tok_err) err_pulses++;
            stalled    = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            stall_last = bus.out_last;
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.tok_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      got_data.delete();
      got_last.delete();
      err_pulses = 0;
   endtask

   task automatic send_token(input logic [6:0] off, input logic [6:0] len, input logic [7:0] lit);
      int n = 0;
      @(negedge clk);
      bus.tok_valid   = 1'b1;
      bus.tok_offset  = off;
      bus.tok_length  = len;
      bus.tok_literal = lit;
      while (!bus.tok_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.tok_ready) begin
         errors++;
         checks++;
         $display("[TB] FAIL token_accept: tok_ready=%b after %0d cycles, expected 1", bus.tok_ready, n);
      end
      @(posedge clk);
      #1;
      bus.tok_valid = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int c = 0;
      while (got_data.size() < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      if (got_data.size() < n) begin
         errors++;
         checks++;
         $display("[TB] FAIL byte_timeout: got %0d bytes, expected %0d", got_data.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.tok_valid   = 1'b0;
      bus.tok_offset  = '0;
      bus.tok_length  = '0;
      bus.tok_literal = '0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_last, bus.tok_err, bus.tok_ready} !== 4'b0000 || bus.out_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_state: got valid=%b last=%b err=%b ready=%b data=%h, expected all 0",
                  bus.out_valid, bus.out_last, bus.tok_err, bus.tok_ready, bus.out_data);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.tok_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready: got %b, expected 1", bus.tok_ready);
      end
   endtask

   task automatic test_literal();
      do_reset();
      send_token(7'd0, 7'd0, 8'h49);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.tok_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL literal_accept_edge: got valid=%b ready=%b, expected valid=0 ready=0",
                  bus.out_valid, bus.tok_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h49 || bus.out_last !== 1'b1 || bus.tok_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL literal_out: got valid=%b data=%h last=%b ready=%b, expected 1 49 1 1",
                  bus.out_valid, bus.out_data, bus.out_last, bus.tok_ready);
      end
   endtask

   task automatic run_overlap_stream(input string name);
      logic [7:0] exp_d [6] = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h42};
      logic       exp_l [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      send_token(7'd0, 7'd0, 8'h41);
      send_token(7'd1, 7'd4, 8'h42);
      wait_bytes(6, 200);
      repeat (8) @(posedge clk);
      checks++;
      if (got_data.size() != 6) begin
         errors++;
         $display("[TB] FAIL %s_count: got %0d bytes, expected 6", name, got_data.size());
      end
      for (int i = 0; i < 6 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
            errors++;
            $display("[TB] FAIL %s_byte%0d: got data=%h last=%b, expected data=%h last=%b",
                     name, i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_overlap();
      do_reset();
      run_overlap_stream("overlap");
   endtask

   task automatic test_backpressure();
      do_reset();
      bp_idx  = 0;
      bp_mode = 1'b1;
      run_overlap_stream("backpressure");
      bp_mode = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 130; i++) begin
         send_token(7'd0, 7'd0, i[7:0]);
      end
      send_token(7'd3, 7'd2, 8'hFF);
      wait_bytes(133, 2000);
      checks++;
      if (got_data.size() != 133) begin
         errors++;
         $display("[TB] FAIL wrap_count: got %0d bytes, expected 133", got_data.size());
      end else begin
         checks++;
         if (got_data[129] !== 8'd129) begin
            errors++;
            $display("[TB] FAIL wrap_lit129: got %h, expected 81", got_data[129]);
         end
         checks++;
         if (got_data[130] !== 8'd127 || got_last[130] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_copy0: got %h last=%b, expected 7f last=0", got_data[130], got_last[130]);
         end
         checks++;
         if (got_data[131] !== 8'd128 || got_last[131] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_copy1: got %h last=%b, expected 80 last=0", got_data[131], got_last[131]);
         end
         checks++;
         if (got_data[132] !== 8'hFF || got_last[132] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_literal: got %h last=%b, expected ff last=1", got_data[132], got_last[132]);
         end
      end
   endtask

   task automatic test_error();
      do_reset();
      send_token(7'd0, 7'd5, 8'h10);
      checks++;
      if (bus.tok_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_pulse_now: got %b, expected 1", bus.tok_err);
      end
      wait_bytes(1, 20);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (err_pulses != 1) begin
         errors++;
         $display("[TB] FAIL err_pulse_count: got %0d, expected 1", err_pulses);
      end
      checks++;
      if (got_data.size() != 1) begin
         errors++;
         $display("[TB] FAIL err_byte_count: got %0d, expected 1", got_data.size());
      end else begin
         checks++;
         if (got_data[0] !== 8'h10 || got_last[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_byte: got %h last=%b, expected 10 last=1", got_data[0], got_last[0]);
         end
      end
   endtask

   task automatic test_reset_mid_copy();
      do_reset();
      send_token(7'd0, 7'd0, 8'h41);
      send_token(7'd1, 7'd6, 8'h42);
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h41) begin
         errors++;
         $display("[TB] FAIL midcopy_first: got valid=%b data=%h, expected 1 41", bus.out_valid, bus.out_data);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.tok_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midcopy_reset: got valid=%b data=%h ready=%b, expected 0 00 0",
                  bus.out_valid, bus.out_data, bus.tok_ready);
      end
      repeat (2) @(negedge clk);
      got_data.delete();
      got_last.delete();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.tok_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midcopy_release_ready: got %b, expected 1", bus.tok_ready);
      end
      repeat (6) @(posedge clk);
      checks++;
      if (got_data.size() != 0) begin
         errors++;
         $display("[TB] FAIL midcopy_no_partial: got %0d bytes, expected 0", got_data.size());
      end
      // History was cleared by reset, so a back-reference reads zero.
      send_token(7'd1, 7'd1, 8'h55);
      wait_bytes(2, 20);
      checks++;
      if (got_data.size() < 2 || got_data[0] !== 8'h00 || got_data[1] !== 8'h55) begin
         errors++;
         $display("[TB] FAIL cleared_history: got %0d bytes first=%h, expected 2 bytes 00 55",
                  got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
      end
   endtask

   initial begin
      test_reset();
      test_literal();
      test_overlap();
      test_backpressure();
      test_wrap();
      test_error();
      test_reset_mid_copy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
